jsoc_sysid_arbiter: RTL and testbench

JSOC_SYSID_ARBITER -- requirements
Module: jsoc_sysid_arbiter

---
 rtl/jsoc_sysid_arbiter.sv | 150 +++++++++++++++
 tb/tb_jsoc_sysid_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jsoc_sysid_arbiter.sv
// Two-master read arbiter in front of a shared system-ID slave, with an optional
// boot-time ID/timestamp check enabled by defining JSOC_SYSID_ID_CHECK_EN.
module jsoc_sysid_arbiter #(
    parameter logic [31:0] EXPECTED_ID = 32'd28,
    parameter logic [31:0] EXPECTED_TS = 32'd1718117590
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        m0_address,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic        m1_address,
    input  logic        m1_read,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic        s_address,
    input  logic [31:0] s_readdata,
    output logic        id_ok,
    output logic        id_fail,
    output logic        check_busy
);

    logic        check_done;
    logic        chk_addr;
    logic        gnt0, gnt1;
    logic        last_grant_q, last_grant_d;
    logic        rdv0_q, rdv1_q;
    logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;

`ifdef JSOC_SYSID_ID_CHECK_EN
    typedef enum logic [1:0] {
        ST_CHK_ID,
        ST_CHK_TS,
        ST_PASS,
        ST_FAIL
    } chk_state_e;

    chk_state_e state_q;
    logic       id_match_q;
    logic       id_ok_q, id_fail_q, check_busy_q;

    // Status flags are registered alongside the state so they change on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_CHK_ID;
            id_match_q   <= 1'b0;
            id_ok_q      <= 1'b0;
            id_fail_q    <= 1'b0;
            check_busy_q <= 1'b1;
        end else begin
            case (state_q)
                ST_CHK_ID: begin
                    id_match_q <= (s_readdata == EXPECTED_ID);
                    state_q    <= ST_CHK_TS;
                end
                ST_CHK_TS: begin
                    check_busy_q <= 1'b0;
                    if (id_match_q && (s_readdata == EXPECTED_TS)) begin
                        state_q <= ST_PASS;
                        id_ok_q <= 1'b1;
                    end else begin
                        state_q   <= ST_FAIL;
                        id_fail_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign check_done = !check_busy_q;
    assign chk_addr   = (state_q == ST_CHK_TS);
    assign id_ok      = id_ok_q;
    assign id_fail    = id_fail_q;
    assign check_busy = check_busy_q;
`else
    logic cfg_unused;
    assign cfg_unused = ^{EXPECTED_ID, EXPECTED_TS};

    assign check_done = 1'b1;
    assign chk_addr   = 1'b0;
    assign id_ok      = 1'b1;
    assign id_fail    = 1'b0;
    assign check_busy = 1'b0;
`endif

    // last_grant_q == 1 means master 1 was served last, so master 0 wins a tie.
    always_comb begin
        gnt0 = m0_read && check_done && (!m1_read || last_grant_q);
        gnt1 = m1_read && check_done && (!m0_read || !last_grant_q);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0) begin
            last_grant_d = 1'b0;
        end else if (gnt1) begin
            last_grant_d = 1'b1;
        end
    end

    always_comb begin
        if (gnt0) begin
            s_address = m0_address;
        end else if (gnt1) begin
            s_address = m1_address;
        end else begin
            s_address = chk_addr;
        end
    end

    assign m0_waitrequest = m0_read && !gnt0;
    assign m1_waitrequest = m1_read && !gnt1;

    always_comb begin
        rd0_d = rd0_q;
        rd1_d = rd1_q;
        if (gnt0) begin
            rd0_d = s_readdata;
        end
        if (gnt1) begin
            rd1_d = s_readdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            rdv0_q       <= 1'b0;
            rdv1_q       <= 1'b0;
            rd0_q        <= '0;
            rd1_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rdv0_q       <= gnt0;
            rdv1_q       <= gnt1;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
        end
    end

    assign m0_readdata      = rd0_q;
    assign m1_readdata      = rd1_q;
    assign m0_readdatavalid = rdv0_q;
    assign m1_readdatavalid = rdv1_q;

endmodule

// File: tb/tb_jsoc_sysid_arbiter.sv
// Scoreboard bench for jsoc_sysid_arbiter; expectations follow JSOC_SYSID_ID_CHECK_EN
// when it is defined for the whole build.
module tb_jsoc_sysid_arbiter;

    localparam logic [31:0] EID = 32'd28;
    localparam logic [31:0] ETS = 32'd1718117590;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        m0_address = 1'b0, m1_address = 1'b0;
    logic        m0_read = 1'b0, m1_read = 1'b0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_address;
    logic [31:0] s_readdata;
    logic        id_ok, id_fail, check_busy;

    logic [31:0] mem0 = EID;
    logic [31:0] mem1 = ETS;

    jsoc_sysid_arbiter #(
        .EXPECTED_ID(EID),
        .EXPECTED_TS(ETS)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_readdata       (s_readdata),
        .id_ok            (id_ok),
        .id_fail          (id_fail),
        .check_busy       (check_busy)
    );

    // Combinational slave model.
    assign s_readdata = s_address ? mem1 : mem0;

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] last_rd[2];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic        exp_busy = 1'b0, exp_ok = 1'b1, exp_fail = 1'b0;
    bit          exp_pass = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_of(input logic a);
        return a ? mem1 : mem0;
    endfunction

    // Monitor: pops an expected response whenever one is due and checks hold otherwise.
    task automatic mon(input int m, input logic v, input logic [31:0] d);
        exp_t e;
        bit   have;
        logic exp_v;
        have  = (m == 0) ? (q0.size() > 0) : (q1.size() > 0);
        exp_v = 1'b0;
        if (have) begin
            e     = (m == 0) ? q0[0] : q1[0];
            exp_v = (e.cyc < cyc);
        end
        chk($sformatf("m%0d_readdatavalid", m), {31'd0, v}, {31'd0, exp_v});
        if (exp_v) begin
            if (m == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            chk($sformatf("m%0d_readdata", m), d, e.data);
            chk($sformatf("m%0d_latency", m), cyc - e.cyc, 1);
            last_rd[m] = e.data;
        end else begin
            chk($sformatf("m%0d_readdata_hold", m), d, last_rd[m]);
        end
    endtask

    always @(negedge clock) begin
        chk("rdv_exclusive", {31'd0, m0_readdatavalid & m1_readdatavalid}, 32'd0);
        mon(0, m0_readdatavalid, m0_readdata);
        mon(1, m1_readdatavalid, m1_readdata);
    end

    // Entered and left at 1 time unit after a rising edge.
    task automatic step(input logic r0, input logic a0, input logic r1, input logic a1,
                        input logic ew0, input logic ew1, input logic esa);
        exp_t e;
        m0_read = r0; m0_address = a0;
        m1_read = r1; m1_address = a1;
        @(negedge clock);
        chk("m0_waitrequest", {31'd0, m0_waitrequest}, {31'd0, ew0});
        chk("m1_waitrequest", {31'd0, m1_waitrequest}, {31'd0, ew1});
        chk("s_address", {31'd0, s_address}, {31'd0, esa});
        chk("check_busy", {31'd0, check_busy}, {31'd0, exp_busy});
        chk("id_ok", {31'd0, id_ok}, {31'd0, exp_ok});
        chk("id_fail", {31'd0, id_fail}, {31'd0, exp_fail});
        if (r0 && !ew0) begin
            e.data = mem_of(a0); e.cyc = cyc; q0.push_back(e);
        end
        if (r1 && !ew1) begin
            e.data = mem_of(a1); e.cyc = cyc; q1.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        m0_read = 1'b0; m1_read = 1'b0;
        m0_address = 1'b0; m1_address = 1'b0;
        reset_n = 1'b0;
        q0.delete(); q1.delete();
        last_rd[0] = '0; last_rd[1] = '0;
        #1;
        chk("rst_async_m0_rdv", {31'd0, m0_readdatavalid}, 32'd0);
        chk("rst_async_m1_rdv", {31'd0, m1_readdatavalid}, 32'd0);
        chk("rst_async_m0_rd", m0_readdata, 32'd0);
        chk("rst_async_m1_rd", m1_readdata, 32'd0);
`ifdef JSOC_SYSID_ID_CHECK_EN
        exp_busy = 1'b1; exp_ok = 1'b0; exp_fail = 1'b0;
`else
        exp_busy = 1'b0; exp_ok = 1'b1; exp_fail = 1'b0;
`endif
        @(negedge clock);
        chk("rst_check_busy", {31'd0, check_busy}, {31'd0, exp_busy});
        chk("rst_id_ok", {31'd0, id_ok}, {31'd0, exp_ok});
        chk("rst_id_fail", {31'd0, id_fail}, {31'd0, exp_fail});
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
`ifdef JSOC_SYSID_ID_CHECK_EN
        // Checker owns the slave for two cycles, address 0 then 1; m0 waits.
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 1);
        exp_busy = 1'b0; exp_ok = exp_pass; exp_fail = !exp_pass;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        last_rd[0] = '0; last_rd[1] = '0;
        #2;
`ifdef JSOC_SYSID_ID_CHECK_EN
        exp_pass = 1'b0;
        mem0 = 32'd29;
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        exp_pass = 1'b1;
        mem0 = EID;
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
`else
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
`endif
        // Arbitration; last grant is m0 at this point.
        step(0, 0, 1, 1, 0, 0, 1);
        step(1, 0, 1, 1, 0, 1, 0);
        step(1, 0, 1, 1, 1, 0, 1);
        step(1, 1, 1, 0, 0, 1, 1);
        step(1, 1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset lands inside an m0 accept cycle: the read must vanish.
        m0_read = 1'b1; m0_address = 1'b1;
        @(negedge clock);
        chk("m0_waitrequest_pre_reset", {31'd0, m0_waitrequest}, 32'd0);
        #1;
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset while a data-valid strobe is being presented.
        step(0, 0, 1, 1, 0, 0, 1);
        chk("m1_rdv_before_async_reset", {31'd0, m1_readdatavalid}, 32'd1);
        do_reset();
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
